// File: rtl/risc_ctrl_seq_p.sv
// Fetch/decode/execute sequencer for the 301 RISC CPU. It drives the execution-unit control word and
// adds memory wait states, one vectored interrupt with shadowed flags, EI/DI/RETI, and HALT wake-up.
module risc_ctrl_seq_p #(
    parameter int IR_W = 16,
    parameter int RA_W = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [IR_W-1:0] ir,
    input  logic            n,
    input  logic            z,
    input  logic            c,
    input  logic            mem_rdy,
    input  logic            irq,
    output logic [RA_W-1:0] w_adr,
    output logic [RA_W-1:0] r_adr,
    output logic [RA_W-1:0] s_adr,
    output logic            adr_sel,
    output logic            s_sel,
    output logic            pc_ld,
    output logic            pc_inc,
    output logic            ir_ld,
    output logic            mw_en,
    output logic            rw_en,
    output logic [1:0]      pc_sel,
    output logic [3:0]      alu_op,
    output logic            epc_ld,
    output logic            irq_ack,
    output logic            ie,
    output logic [7:0]      status
);

    // Exec/INT encodings equal their 5-bit status code, so status can use the state value directly.
    typedef enum logic [4:0] {
        S_ADD = 5'd0, S_SUB, S_CMP, S_MOV, S_SHL, S_SHR, S_INC, S_DEC,
        S_LLD, S_STO, S_LDI, S_HALT, S_JE, S_JNE, S_JC, S_JMP,
        S_INT, S_RETI, S_EI, S_DI, S_RESET, S_FETCH, S_DECODE, S_ILLEGAL
    } state_t;

    state_t          state;
    logic [2:0]      ps;      // {N,Z,C}
    logic [2:0]      shadow;
    logic [6:0]      opcode;
    logic [RA_W-1:0] fld_w, fld_r, fld_s;
    logic [4:0]      state_code;
    state_t          boundary;

    assign opcode     = ir[IR_W-1 -: 7];
    assign fld_w      = ir[3*RA_W-1 -: RA_W];
    assign fld_r      = ir[2*RA_W-1 -: RA_W];
    assign fld_s      = ir[RA_W-1:0];
    assign state_code = state;
    assign boundary   = (irq && ie) ? S_INT : S_FETCH;

    function automatic state_t decode(input logic [6:0] op);
        if (op[6:4] == 3'b111) return state_t'({1'b0, op[3:0]});
        case (op)
            7'h6C:   return S_RETI;
            7'h6D:   return S_EI;
            7'h6E:   return S_DI;
            default: return S_ILLEGAL;
        endcase
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_RESET;
            ps     <= 3'b000;
            shadow <= 3'b000;
            ie     <= 1'b0;
        end else begin
            case (state)
                S_RESET:  state <= S_FETCH;
                S_FETCH:  if (mem_rdy) state <= S_DECODE;
                S_DECODE: state <= decode(opcode);
                S_ADD, S_SUB, S_CMP, S_SHL, S_SHR, S_INC, S_DEC: begin
                    ps    <= {n, z, c};
                    state <= boundary;
                end
                S_MOV, S_JE, S_JNE, S_JC, S_JMP: state <= boundary;
                S_LLD, S_STO, S_LDI: if (mem_rdy) state <= boundary;
                S_HALT:   if (irq && ie) state <= S_INT;
                S_INT: begin
                    shadow <= ps;
                    ie     <= 1'b0;
                    state  <= S_FETCH;
                end
                S_RETI: begin
                    ps    <= shadow;
                    ie    <= 1'b1;
                    state <= S_FETCH;
                end
                // EI's own boundary already sees interrupts enabled; DI's already sees them disabled.
                S_EI: begin
                    ie    <= 1'b1;
                    state <= irq ? S_INT : S_FETCH;
                end
                S_DI: begin
                    ie    <= 1'b0;
                    state <= S_FETCH;
                end
                default:  state <= state;
            endcase
        end
    end

    always_comb begin
        w_adr   = '0;
        r_adr   = '0;
        s_adr   = '0;
        adr_sel = 1'b0;
        s_sel   = 1'b0;
        pc_ld   = 1'b0;
        pc_inc  = 1'b0;
        ir_ld   = 1'b0;
        mw_en   = 1'b0;
        rw_en   = 1'b0;
        pc_sel  = 2'b00;
        alu_op  = 4'b0000;
        epc_ld  = 1'b0;
        irq_ack = 1'b0;
        status  = {ps, state_code};
        case (state)
            S_RESET:   status = 8'hFF;
            S_FETCH: begin
                ir_ld  = mem_rdy;
                pc_inc = mem_rdy;
                status = 8'h80;
            end
            S_DECODE:  status = 8'hC0;
            S_ILLEGAL: status = 8'hF0;
            S_ADD, S_SUB, S_CMP, S_MOV, S_SHL, S_SHR, S_INC, S_DEC: begin
                w_adr = fld_w;
                r_adr = fld_r;
                s_adr = fld_s;
                rw_en = (state != S_CMP);
                case (state)
                    S_ADD:          alu_op = 4'b0100;
                    S_SUB, S_CMP:   alu_op = 4'b0101;
                    S_SHL:          alu_op = 4'b0111;
                    S_SHR:          alu_op = 4'b0110;
                    S_INC:          alu_op = 4'b0010;
                    S_DEC:          alu_op = 4'b0011;
                    default:        alu_op = 4'b0000;
                endcase
            end
            S_LLD: begin
                w_adr   = fld_w;
                r_adr   = fld_s;
                adr_sel = 1'b1;
                s_sel   = 1'b1;
                rw_en   = mem_rdy;
            end
            S_STO: begin
                r_adr   = fld_w;
                s_adr   = fld_s;
                adr_sel = 1'b1;
                mw_en   = 1'b1;
            end
            S_LDI: begin
                w_adr  = fld_w;
                s_sel  = 1'b1;
                rw_en  = mem_rdy;
                pc_inc = mem_rdy;
            end
            S_JE:  pc_ld = ps[1];
            S_JNE: pc_ld = !ps[1];
            S_JC:  pc_ld = ps[0];
            S_JMP: begin
                pc_ld  = 1'b1;
                pc_sel = 2'b01;
                s_adr  = fld_s;
            end
            S_INT: begin
                epc_ld  = 1'b1;
                pc_ld   = 1'b1;
                pc_sel  = 2'b10;
                irq_ack = 1'b1;
            end
            S_RETI: begin
                pc_ld  = 1'b1;
                pc_sel = 2'b11;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_risc_ctrl_seq_p.sv
// Scoreboarded bench for risc_ctrl_seq_p: expected control words are queued as each cycle's
// stimulus is applied and compared against the DUT at the following falling edge.
module tb_risc_ctrl_seq_p;

    logic        clk;
    logic        reset;
    logic [15:0] ir;
    logic        n, z, c, mem_rdy, irq;
    logic [2:0]  w_adr, r_adr, s_adr;
    logic        adr_sel, s_sel, pc_ld, pc_inc, ir_ld, mw_en, rw_en;
    logic [1:0]  pc_sel;
    logic [3:0]  alu_op;
    logic        epc_ld, irq_ack, ie;
    logic [7:0]  status;
    logic [32:0] obs;

    risc_ctrl_seq_p #(.IR_W(16), .RA_W(3)) dut (
        .clk(clk), .reset(reset), .ir(ir), .n(n), .z(z), .c(c),
        .mem_rdy(mem_rdy), .irq(irq),
        .w_adr(w_adr), .r_adr(r_adr), .s_adr(s_adr),
        .adr_sel(adr_sel), .s_sel(s_sel), .pc_ld(pc_ld), .pc_inc(pc_inc),
        .ir_ld(ir_ld), .mw_en(mw_en), .rw_en(rw_en), .pc_sel(pc_sel),
        .alu_op(alu_op), .epc_ld(epc_ld), .irq_ack(irq_ack), .ie(ie),
        .status(status)
    );

    assign obs = {w_adr, r_adr, s_adr, adr_sel, s_sel, pc_ld, pc_inc, ir_ld, mw_en, rw_en,
                  pc_sel, alu_op, epc_ld, irq_ack, ie, status};

    localparam logic [32:0] M_ALL   = {33{1'b1}};
    localparam logic [32:0] M_NOADR = {9'b0, {24{1'b1}}};
    localparam logic [32:0] M_S     = {6'b0, 3'b111, {24{1'b1}}};
    localparam logic [32:0] M_R     = {3'b0, 3'b111, 3'b0, {24{1'b1}}};

    typedef struct {
        string       tag;
        logic [32:0] mask;
        logic [32:0] exp;
    } sb_t;

    sb_t sbq[$];
    int  n_cmp = 0;
    int  n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [32:0] got, input logic [32:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // ctl = {adr_sel, s_sel, pc_ld, pc_inc, ir_ld, mw_en, rw_en}; eai = {epc_ld, irq_ack, ie}
    function automatic logic [32:0] cw(input logic [2:0] w, input logic [2:0] r, input logic [2:0] s,
                                       input logic [6:0] ctl, input logic [1:0] psel,
                                       input logic [3:0] alu, input logic [2:0] eai,
                                       input logic [7:0] st);
        return {w, r, s, ctl, psel, alu, eai, st};
    endfunction

    function automatic logic [15:0] ins(input logic [6:0] op, input logic [2:0] w,
                                        input logic [2:0] r, input logic [2:0] s);
        return {op, w, r, s};
    endfunction

    task automatic cyc(input string tag, input logic [32:0] mask, input logic [32:0] e);
        sb_t item;
        item.tag  = tag;
        item.mask = mask;
        item.exp  = e;
        sbq.push_back(item);
        @(negedge clk);
        item = sbq.pop_front();
        check_val(item.tag, obs & item.mask, item.exp & item.mask);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_dec(input logic [15:0] i, input logic iev, input string nm);
        ir      = i;
        mem_rdy = 1'b1;
        cyc({nm, "_fetch"}, M_ALL, cw(0, 0, 0, 7'b0001100, 0, 0, {2'b00, iev}, 8'h80));
        mem_rdy = 1'b0;
        cyc({nm, "_dec"}, M_ALL, cw(0, 0, 0, 7'b0, 0, 0, {2'b00, iev}, 8'hC0));
    endtask

    initial begin
        reset = 1'b0; ir = '0; n = 0; z = 0; c = 0; mem_rdy = 0; irq = 0;
        #2 reset = 1'b1;
        @(posedge clk); #1;
        cyc("reset", M_ALL, cw(0, 0, 0, 0, 0, 0, 0, 8'hFF));
        reset = 1'b0;
        cyc("rst_idle", M_ALL, cw(0, 0, 0, 0, 0, 0, 0, 8'hFF));

        // Fetch wait states, then ADD R3 <= R2 + R1
        ir = 16'hE0D1;
        for (int i = 0; i < 3; i++) cyc("fetch_wait", M_ALL, cw(0, 0, 0, 0, 0, 0, 0, 8'h80));
        fetch_dec(16'hE0D1, 1'b0, "add");
        n = 0; z = 1; c = 1;
        cyc("add", M_ALL, cw(3, 2, 1, 7'b0000001, 0, 4'b0100, 0, 8'h00));

        fetch_dec(ins(7'h7C, 0, 0, 0), 1'b0, "je");
        cyc("je", M_NOADR, cw(0, 0, 0, 7'b0010000, 0, 0, 0, 8'h6C));

        fetch_dec(ins(7'h6D, 0, 0, 0), 1'b0, "ei");
        cyc("ei", M_NOADR, cw(0, 0, 0, 0, 0, 0, 0, 8'h72));

        // Interrupt taken at the INC boundary
        fetch_dec(ins(7'h76, 4, 0, 5), 1'b1, "inc");
        irq = 1; n = 1; z = 0; c = 0;
        cyc("inc", M_NOADR, cw(0, 0, 0, 7'b0000001, 0, 4'b0010, 3'b001, 8'h66));
        cyc("int", M_ALL, cw(0, 0, 0, 7'b0010000, 2'b10, 0, 3'b111, 8'h90));
        irq = 0;

        fetch_dec(ins(7'h71, 1, 2, 3), 1'b0, "sub");
        n = 0; z = 0; c = 1;
        cyc("sub", M_NOADR, cw(0, 0, 0, 7'b0000001, 0, 4'b0101, 0, 8'h81));

        fetch_dec(ins(7'h6C, 0, 0, 0), 1'b0, "reti");
        cyc("reti", M_NOADR, cw(0, 0, 0, 7'b0010000, 2'b11, 0, 0, 8'h31));

        // Restored flags 100 must show up and survive MOV
        fetch_dec(ins(7'h73, 1, 2, 3), 1'b1, "mov");
        n = 1; z = 1; c = 1;
        cyc("mov", M_NOADR, cw(0, 0, 0, 7'b0000001, 0, 4'b0000, 3'b001, 8'h83));

        fetch_dec(ins(7'h7E, 0, 0, 0), 1'b1, "jc");
        cyc("jc", M_NOADR, cw(0, 0, 0, 7'b0, 0, 0, 3'b001, 8'h8E));

        fetch_dec(ins(7'h7F, 0, 0, 5), 1'b1, "jmp");
        cyc("jmp", M_S, cw(0, 0, 5, 7'b0010000, 2'b01, 0, 3'b001, 8'h8F));

        fetch_dec(ins(7'h6E, 0, 0, 0), 1'b1, "di");
        irq = 1;
        cyc("di", M_NOADR, cw(0, 0, 0, 7'b0, 0, 0, 3'b001, 8'h93));

        // HALT with interrupts disabled holds even with irq asserted
        fetch_dec(ins(7'h7B, 0, 0, 0), 1'b0, "halt");
        for (int i = 0; i < 2; i++) cyc("halt_hold", M_NOADR, cw(0, 0, 0, 0, 0, 0, 0, 8'h8B));
        reset = 1'b1;
        cyc("rst_halt", M_ALL, cw(0, 0, 0, 0, 0, 0, 0, 8'hFF));
        reset = 1'b0; irq = 0;
        cyc("rst_idle2", M_ALL, cw(0, 0, 0, 0, 0, 0, 0, 8'hFF));

        fetch_dec(ins(7'h6D, 0, 0, 0), 1'b0, "ei2");
        cyc("ei2", M_NOADR, cw(0, 0, 0, 0, 0, 0, 0, 8'h12));
        fetch_dec(ins(7'h7B, 0, 0, 0), 1'b1, "halt2");
        cyc("halt_ie", M_NOADR, cw(0, 0, 0, 0, 0, 0, 3'b001, 8'h0B));
        irq = 1;
        cyc("halt_wake", M_NOADR, cw(0, 0, 0, 0, 0, 0, 3'b001, 8'h0B));
        cyc("int2", M_ALL, cw(0, 0, 0, 7'b0010000, 2'b10, 0, 3'b111, 8'h10));
        irq = 0;

        // Illegal opcode locks until an asynchronous reset
        fetch_dec(ins(7'h10, 0, 0, 0), 1'b0, "ill");
        for (int i = 0; i < 10; i++) cyc("illegal", M_ALL, cw(0, 0, 0, 0, 0, 0, 0, 8'hF0));
        reset = 1'b1;
        cyc("rst_ill", M_ALL, cw(0, 0, 0, 0, 0, 0, 0, 8'hFF));
        reset = 1'b0;
        cyc("rst_idle3", M_ALL, cw(0, 0, 0, 0, 0, 0, 0, 8'hFF));

        // Memory instructions with wait states
        fetch_dec(ins(7'h79, 2, 0, 6), 1'b0, "sto");
        for (int i = 0; i < 2; i++) cyc("sto_wait", M_ALL, cw(0, 2, 6, 7'b1000010, 0, 0, 0, 8'h09));
        mem_rdy = 1;
        cyc("sto_done", M_ALL, cw(0, 2, 6, 7'b1000010, 0, 0, 0, 8'h09));

        fetch_dec(ins(7'h7A, 5, 0, 0), 1'b0, "ldi");
        cyc("ldi_wait", M_NOADR, cw(0, 0, 0, 7'b0100000, 0, 0, 0, 8'h0A));
        mem_rdy = 1;
        cyc("ldi_done", M_NOADR, cw(0, 0, 0, 7'b0101001, 0, 0, 0, 8'h0A));

        fetch_dec(ins(7'h78, 1, 0, 7), 1'b0, "lld");
        mem_rdy = 1;
        cyc("lld", M_R, cw(0, 7, 0, 7'b1100001, 0, 0, 0, 8'h08));

        fetch_dec(ins(7'h79, 2, 0, 6), 1'b0, "sto2");
        cyc("sto2_wait", M_ALL, cw(0, 2, 6, 7'b1000010, 0, 0, 0, 8'h09));
        reset = 1'b1;
        cyc("sto_abort", M_ALL, cw(0, 0, 0, 0, 0, 0, 0, 8'hFF));
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
